// File: rtl/aer_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : aer_tx_arbiter
//  Description : Shares one byte stream toward the UART transmitter between
//                AER spike events (2-byte frames) and readback words
//                (3-byte frames). Whole frames only, round-robin on ties.
//  Revision    : 1.0 - initial release
// ============================================================================
module aer_tx_arbiter #(
    parameter logic [7:0] HDR_SPIKE = 8'hF0,
    parameter logic [7:0] HDR_RB    = 8'hF1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  AEROUT_ADDR,
    input  logic        AEROUT_REQ,
    output logic        AEROUT_ACK,
    input  logic [15:0] rb_data,
    input  logic        rb_valid,
    output logic        rb_ready,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        busy
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_SEND_HDR = 2'd1;
    localparam logic [1:0] c_SEND_B1  = 2'd2;
    localparam logic [1:0] c_SEND_B2  = 2'd3;

    logic [1:0]  r_state;
    logic [7:0]  r_tdata;
    logic        r_tvalid;
    logic        r_ack;
    logic        r_last_rb;     // 1: readback was the most recent grant
    logic        r_is_rb;       // frame in flight is a readback frame
    logic [7:0]  r_addr;
    logic [15:0] r_rb_data;

    logic [1:0]  w_state_nxt;
    logic [7:0]  w_tdata_nxt;
    logic        w_tvalid_nxt;
    logic        w_grant_spk;
    logic        w_grant_rb;
    logic        w_spk_done;
    logic        w_spk_elig;
    logic        w_rb_elig;
    logic        w_accept;

    // A spike that is already acknowledged must not be served again until
    // the 4-phase handshake returns to zero.
    assign w_spk_elig = AEROUT_REQ && !r_ack;
    assign w_rb_elig  = rb_valid;
    assign w_accept   = r_tvalid && m_axis_tready;

    // Next-state, next-output and grant decision.
    always_comb begin
        w_state_nxt  = r_state;
        w_tdata_nxt  = r_tdata;
        w_tvalid_nxt = r_tvalid;
        w_grant_spk  = 1'b0;
        w_grant_rb   = 1'b0;
        w_spk_done   = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_tvalid_nxt = 1'b0;
                if (w_spk_elig && (!w_rb_elig || r_last_rb)) begin
                    w_grant_spk  = 1'b1;
                    w_state_nxt  = c_SEND_HDR;
                    w_tvalid_nxt = 1'b1;
                    w_tdata_nxt  = HDR_SPIKE;
                end else if (w_rb_elig) begin
                    w_grant_rb   = 1'b1;
                    w_state_nxt  = c_SEND_HDR;
                    w_tvalid_nxt = 1'b1;
                    w_tdata_nxt  = HDR_RB;
                end
            end
            c_SEND_HDR: begin
                if (w_accept) begin
                    w_state_nxt = c_SEND_B1;
                    w_tdata_nxt = r_is_rb ? r_rb_data[15:8] : r_addr;
                end
            end
            c_SEND_B1: begin
                if (w_accept) begin
                    if (r_is_rb) begin
                        w_state_nxt = c_SEND_B2;
                        w_tdata_nxt = r_rb_data[7:0];
                    end else begin
                        w_state_nxt  = c_IDLE;
                        w_tvalid_nxt = 1'b0;
                        w_spk_done   = 1'b1;
                    end
                end
            end
            default: begin
                if (w_accept) begin
                    w_state_nxt  = c_IDLE;
                    w_tvalid_nxt = 1'b0;
                end
            end
        endcase
    end

    // State, output byte, captured payloads, round-robin pointer and ACK.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= c_IDLE;
            r_tdata   <= 8'h00;
            r_tvalid  <= 1'b0;
            r_ack     <= 1'b0;
            r_last_rb <= 1'b1;
            r_is_rb   <= 1'b0;
            r_addr    <= 8'h00;
            r_rb_data <= 16'h0000;
        end else begin
            r_state  <= w_state_nxt;
            r_tdata  <= w_tdata_nxt;
            r_tvalid <= w_tvalid_nxt;
            if (w_grant_spk) begin
                r_addr    <= AEROUT_ADDR;
                r_is_rb   <= 1'b0;
                r_last_rb <= 1'b0;
            end else if (w_grant_rb) begin
                r_rb_data <= rb_data;
                r_is_rb   <= 1'b1;
                r_last_rb <= 1'b1;
            end
            // ACK rises after the last spike byte even if REQ already fell;
            // it then drops once REQ is seen low.
            if (w_spk_done) begin
                r_ack <= 1'b1;
            end else if (r_ack && !AEROUT_REQ) begin
                r_ack <= 1'b0;
            end
        end
    end

    assign rb_ready      = rst && w_grant_rb;
    assign AEROUT_ACK    = r_ack;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign busy          = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_aer_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aer_tx_arbiter
//  Description : Self-checking bench for aer_tx_arbiter. A frame-queue model
//                predicts every output each cycle; directed phases followed
//                by randomized traffic drive the inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aer_tx_arbiter;

    localparam logic [7:0] c_HDR_SPIKE = 8'hF0;
    localparam logic [7:0] c_HDR_RB    = 8'hF1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  AEROUT_ADDR = 8'h00;
    logic        AEROUT_REQ = 1'b0;
    logic        AEROUT_ACK;
    logic [15:0] rb_data = 16'h0000;
    logic        rb_valid = 1'b0;
    logic        rb_ready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    aer_tx_arbiter #(
        .HDR_SPIKE (c_HDR_SPIKE),
        .HDR_RB    (c_HDR_RB)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .AEROUT_ADDR   (AEROUT_ADDR),
        .AEROUT_REQ    (AEROUT_REQ),
        .AEROUT_ACK    (AEROUT_ACK),
        .rb_data       (rb_data),
        .rb_valid      (rb_valid),
        .rb_ready      (rb_ready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: the frame in flight is a queue of bytes still to be
    // delivered; the head is what must be on the bus.
    // ------------------------------------------------------------------
    logic [7:0] m_q[$];
    bit         m_ack       = 1'b0;
    bit         m_last_rb   = 1'b1;
    bit         m_frame_spk = 1'b0;
    bit         m_tdata_zero = 1'b1;
    bit         m_rb_took   = 1'b0;

    function automatic bit want_spk();
        bit spk_e;
        bit rb_e;
        spk_e = AEROUT_REQ && !m_ack;
        rb_e  = rb_valid;
        return (m_q.size() == 0) && spk_e && (!rb_e || m_last_rb);
    endfunction

    function automatic bit want_rb();
        bit spk_e;
        bit rb_e;
        spk_e = AEROUT_REQ && !m_ack;
        rb_e  = rb_valid;
        return (m_q.size() == 0) && rb_e && (!spk_e || !m_last_rb);
    endfunction

    always @(posedge clk) begin
        bit done;
        bit gs;
        bit gr;
        done      = 1'b0;
        m_rb_took = 1'b0;
        if (!rst) begin
            m_q.delete();
            m_ack        = 1'b0;
            m_last_rb    = 1'b1;
            m_tdata_zero = 1'b1;
        end else begin
            gs = want_spk();
            gr = want_rb();
            if (m_q.size() == 0) begin
                if (gs) begin
                    m_q = '{c_HDR_SPIKE, AEROUT_ADDR};
                    m_frame_spk  = 1'b1;
                    m_last_rb    = 1'b0;
                    m_tdata_zero = 1'b0;
                end else if (gr) begin
                    m_q = '{c_HDR_RB, rb_data[15:8], rb_data[7:0]};
                    m_frame_spk  = 1'b0;
                    m_last_rb    = 1'b1;
                    m_tdata_zero = 1'b0;
                    m_rb_took    = 1'b1;
                end
            end else if (m_axis_tready) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0 && m_frame_spk) done = 1'b1;
            end
            if (done) m_ack = 1'b1;
            else if (m_ack && !AEROUT_REQ) m_ack = 1'b0;
        end
        chk_en = 1'b1;
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    // Compare every output mid-cycle, well away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("tvalid", 16'(m_axis_tvalid), 16'(m_q.size() != 0));
            check_eq("busy", 16'(busy), 16'(m_q.size() != 0));
            check_eq("ack", 16'(AEROUT_ACK), 16'(m_ack));
            check_eq("rb_ready", 16'(rb_ready), 16'(rst && want_rb()));
            if (m_q.size() != 0) check_eq("tdata", 16'(m_axis_tdata), 16'(m_q[0]));
            else if (m_tdata_zero) check_eq("tdata_rst", 16'(m_axis_tdata), 16'h0000);
        end
    end

    // One clock of stimulus time; a readback word leaves once accepted.
    task automatic cycle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (m_rb_took) rb_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cycle(2);
        rst = 1'b1;
    endtask

    initial begin
        // Reset state.
        do_reset();
        cycle(2);

        // Single spike, then the 4-phase return to zero.
        AEROUT_ADDR = 8'h3C; AEROUT_REQ = 1'b1; m_axis_tready = 1'b1;
        cycle(5);
        AEROUT_ADDR = 8'hAA;
        AEROUT_REQ  = 1'b0;
        cycle(4);

        // Readback with alternating backpressure.
        rb_data = 16'hBEEF; rb_valid = 1'b1;
        for (int i = 0; i < 14; i++) begin
            m_axis_tready = i[0];
            cycle(1);
            rb_data = 16'h0000;
        end
        m_axis_tready = 1'b1;
        cycle(3);

        // Tie right after reset, then a second tie after the ACK completes.
        do_reset();
        AEROUT_ADDR = 8'h05; AEROUT_REQ = 1'b1;
        rb_data = 16'h1234; rb_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle(1);
            if (m_ack) AEROUT_REQ = 1'b0;
        end
        AEROUT_ADDR = 8'h06; AEROUT_REQ = 1'b1;
        rb_data = 16'h5678; rb_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle(1);
            if (m_ack) AEROUT_REQ = 1'b0;
        end

        // ACK hold: REQ stays high while readback pulses are served.
        AEROUT_ADDR = 8'h77; AEROUT_REQ = 1'b1;
        cycle(5);
        for (int i = 0; i < 4; i++) begin
            rb_data = 16'(32'hA000 + i); rb_valid = 1'b1;
            cycle(6);
        end
        AEROUT_REQ = 1'b0;
        cycle(4);

        // Reset while the second byte of a readback frame is on the bus.
        rb_data = 16'hC0DE; rb_valid = 1'b1;
        cycle(2);
        rst = 1'b0;
        cycle(1);
        rst = 1'b1;
        cycle(5);

        // Long stall on the spike header with readback pending.
        AEROUT_ADDR = 8'h42; AEROUT_REQ = 1'b1; m_axis_tready = 1'b0;
        cycle(1);
        rb_data = 16'h9999; rb_valid = 1'b1;
        cycle(100);
        m_axis_tready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle(1);
            if (m_ack) AEROUT_REQ = 1'b0;
        end

        // Randomized traffic, including occasional resets and early REQ drops.
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 299) != 0);
            if (m_ack) begin
                if ($urandom_range(0, 2) == 0) AEROUT_REQ = 1'b0;
            end else if (!AEROUT_REQ) begin
                AEROUT_REQ = ($urandom_range(0, 3) == 0);
            end else if ($urandom_range(0, 29) == 0) begin
                AEROUT_REQ = 1'b0;
            end
            AEROUT_ADDR   = 8'($urandom);
            rb_data       = 16'($urandom);
            m_axis_tready = ($urandom_range(0, 3) != 0);
            if (!rb_valid) rb_valid = ($urandom_range(0, 3) == 0);
            cycle(1);
        end

        rst = 1'b1;
        AEROUT_REQ = 1'b0; rb_valid = 1'b0; m_axis_tready = 1'b1;
        cycle(8);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
